// File: rtl/inst_queue_if.sv
// Instruction queue payload type and push/pop bundle.
// Ports: i_set1/i_set2/i_valid push side (o_ready back), o_set1/o_set2/o_is_valid
//        pop side (i_usingNUM back). master = decode/issue side, slave = the queue.
package inst_queue_pkg;

  // One decoded instruction slot. o_valid travels with the payload but the
  // queue's own o_is_valid is what qualifies an entry on the read side.
  typedef struct packed {
    logic [31:0] PC;
    logic [31:0] instr;
    logic        o_valid;
  } PC_set;

endpackage

interface inst_queue_if;
  import inst_queue_pkg::*;

  PC_set       i_set1;
  PC_set       i_set2;
  logic [1:0]  i_valid;
  logic        o_ready;
  PC_set       o_set1;
  PC_set       o_set2;
  logic [1:0]  o_is_valid;
  logic [1:0]  i_usingNUM;

  modport master (
    output i_set1, i_set2, i_valid, i_usingNUM,
    input  o_ready, o_set1, o_set2, o_is_valid
  );

  modport slave (
    input  i_set1, i_set2, i_valid, i_usingNUM,
    output o_ready, o_set1, o_set2, o_is_valid
  );

endinterface

// File: rtl/inst_queue.sv
// Circular instruction queue: up to two pushes and two pops per cycle.
// Latency: pushed entry visible on o_set1/o_set2 the cycle after the push.
// Backpressure: o_ready low (fewer than two free slots) drops the whole push.
// Ports: clk, rstn (async active-low), flush (sync discard), stall (blocks pop),
//        q (inst_queue_if.slave) carrying push pair, ready, head pair and valids.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       flush,
  input  logic       stall,
  inst_queue_if.slave q
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  PC_set         mem_q [DEPTH];
  PC_set         mem_d [DEPTH];

  logic          ready;
  logic [1:0]    npush;
  logic [1:0]    npop;
  logic [1:0]    req_pop;

  // Ready is judged on the pre-update count so a same-cycle pop never
  // makes room for a push.
  assign ready = (count_q <= CW'(DEPTH - 2));

  // A request of 3 is clamped to the two read ports we actually have.
  assign req_pop = (q.i_usingNUM == 2'd3) ? 2'd2 : q.i_usingNUM;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    npush   = 2'd0;
    npop    = 2'd0;

    if (!stall) begin
      npop = (CW'(req_pop) > count_q) ? count_q[1:0] : req_pop;
    end

    if (ready) begin
      unique case (q.i_valid)
        2'b11: begin
          mem_d[tail_q]         = q.i_set1;
          mem_d[tail_q + AW'(1)] = q.i_set2;
          npush                 = 2'd2;
        end
        2'b10: begin
          mem_d[tail_q] = q.i_set1;
          npush         = 2'd1;
        end
        // Lone younger instruction is compacted into the tail slot.
        2'b01: begin
          mem_d[tail_q] = q.i_set2;
          npush         = 2'd1;
        end
        default: npush = 2'd0;
      endcase
    end

    head_d  = head_q + AW'(npop);
    tail_d  = tail_q + AW'(npush);
    count_d = count_q + CW'(npush) - CW'(npop);

    // Flush wins over everything; storage is left as is since the pointers
    // alone define what is live.
    if (flush) begin
      mem_d   = mem_q;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  assign q.o_ready    = ready;
  assign q.o_set1     = mem_q[head_q];
  assign q.o_set2     = mem_q[head_q + AW'(1)];
  assign q.o_is_valid = {(count_q >= CW'(1)), (count_q >= CW'(2))};

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue with a queue-based reference model.
// Latency: model updated at each rising edge, compared on the falling edge.
// Backpressure: model drops a push whenever fewer than two slots were free.
module tb_inst_queue;
  import inst_queue_pkg::*;

  localparam int DEPTH = 8;

  logic clk;
  logic rstn;
  logic flush;
  logic stall;

  inst_queue_if qif ();

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .stall (stall),
    .q     (qif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;
  PC_set mq[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic PC_set mk(input logic [31:0] pc);
    PC_set m;
    m.PC      = pc;
    m.instr   = pc ^ 32'hdeadbeef;
    m.o_valid = pc[2];
    return m;
  endfunction

  // Compare process: outputs derived from the model queue contents.
  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_ready", 128'(qif.o_ready), 128'(1'b1));
      chk("rst_valid", 128'(qif.o_is_valid), 128'(2'b00));
      chk("rst_set1", 128'(qif.o_set1), 128'(0));
      chk("rst_set2", 128'(qif.o_set2), 128'(0));
    end else begin
      chk("ready", 128'(qif.o_ready), 128'(mq.size() <= DEPTH - 2));
      chk("is_valid", 128'(qif.o_is_valid), 128'({mq.size() >= 1, mq.size() >= 2}));
      if (mq.size() >= 1) chk("set1", 128'(qif.o_set1), 128'(mq[0]));
      if (mq.size() >= 2) chk("set2", 128'(qif.o_set2), 128'(mq[1]));
    end
  end

  task automatic model_step(input logic fl, input logic st, input logic [1:0] iv,
                            input PC_set s1, input PC_set s2, input logic [1:0] un);
    int sz;
    int n;
    bit rdy;
    sz  = mq.size();
    rdy = (sz <= DEPTH - 2);
    if (fl) begin
      mq.delete();
    end else begin
      n = st ? 0 : ((un == 2'd0) ? 0 : (un == 2'd1) ? 1 : 2);
      if (n > sz) n = sz;
      repeat (n) void'(mq.pop_front());
      if (rdy) begin
        if (iv[1]) mq.push_back(s1);
        if (iv[0]) mq.push_back(s2);
      end
    end
  endtask

  task automatic cyc(input logic fl, input logic st, input logic [1:0] iv,
                     input logic [31:0] p1, input logic [31:0] p2, input logic [1:0] un);
    flush = fl;
    stall = st;
    qif.i_valid    = iv;
    qif.i_set1     = mk(p1);
    qif.i_set2     = mk(p2);
    qif.i_usingNUM = un;
    @(posedge clk);
    model_step(fl, st, iv, mk(p1), mk(p2), un);
    #1;
    flush = 1'b0;
    stall = 1'b0;
    qif.i_valid    = 2'b00;
    qif.i_usingNUM = 2'd0;
    @(negedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rstn  = 1'b0;
    flush = 1'b0;
    stall = 1'b0;
    qif.i_valid    = 2'b00;
    qif.i_set1     = '0;
    qif.i_set2     = '0;
    qif.i_usingNUM = 2'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("lit_rst_ready", 128'(qif.o_ready), 128'(1'b1));
    chk("lit_rst_valid", 128'(qif.o_is_valid), 128'(2'b00));
    rstn = 1'b1;

    // First pair visible next cycle.
    cyc(0, 0, 2'b11, 32'h1c000000, 32'h1c000004, 2'd0);
    chk("lit_first_valid", 128'(qif.o_is_valid), 128'(2'b11));
    chk("lit_first_set1", 128'(qif.o_set1.PC), 128'(32'h1c000000));
    chk("lit_first_set2", 128'(qif.o_set2.PC), 128'(32'h1c000004));

    // Fill to full, then a dropped push, then drain two.
    cyc(0, 0, 2'b11, 32'h1c000008, 32'h1c00000c, 2'd0);
    cyc(0, 0, 2'b11, 32'h1c000010, 32'h1c000014, 2'd0);
    cyc(0, 0, 2'b11, 32'h1c000018, 32'h1c00001c, 2'd0);
    chk("lit_full_cnt", 128'(mq.size()), 128'(8));
    chk("lit_full_ready", 128'(qif.o_ready), 128'(1'b0));
    cyc(0, 0, 2'b11, 32'h1c0000f0, 32'h1c0000f4, 2'd0);
    chk("lit_drop_cnt", 128'(mq.size()), 128'(8));
    chk("lit_drop_set1", 128'(qif.o_set1.PC), 128'(32'h1c000000));
    cyc(0, 0, 2'b00, 32'h0, 32'h0, 2'd2);
    chk("lit_drain_ready", 128'(qif.o_ready), 128'(1'b1));
    chk("lit_drain_set1", 128'(qif.o_set1.PC), 128'(32'h1c000008));

    // Walk head to index 7, then wrap.
    cyc(0, 0, 2'b00, 32'h0, 32'h0, 2'd2);
    cyc(0, 0, 2'b00, 32'h0, 32'h0, 2'd2);
    cyc(0, 0, 2'b00, 32'h0, 32'h0, 2'd1);
    cyc(0, 0, 2'b11, 32'h1c000020, 32'h1c000024, 2'd0);
    chk("lit_wrap_set1", 128'(qif.o_set1.PC), 128'(32'h1c00001c));
    chk("lit_wrap_set2", 128'(qif.o_set2.PC), 128'(32'h1c000020));
    cyc(0, 0, 2'b11, 32'h1c000028, 32'h1c00002c, 2'd2);
    chk("lit_pp_cnt", 128'(mq.size()), 128'(3));
    chk("lit_pp_set1", 128'(qif.o_set1.PC), 128'(32'h1c000024));
    chk("lit_pp_set2", 128'(qif.o_set2.PC), 128'(32'h1c000028));

    // Stall blocks the pop; single younger push compacts.
    cyc(0, 0, 2'b00, 32'h0, 32'h0, 2'd2);
    cyc(0, 1, 2'b01, 32'h1c000200, 32'h1c000100, 2'd2);
    chk("lit_stall_valid", 128'(qif.o_is_valid), 128'(2'b11));
    chk("lit_stall_set1", 128'(qif.o_set1.PC), 128'(32'h1c00002c));
    chk("lit_stall_set2", 128'(qif.o_set2.PC), 128'(32'h1c000100));

    // usingNUM=3 clamps to 2; pop saturates at the occupancy.
    cyc(0, 0, 2'b00, 32'h0, 32'h0, 2'd3);
    chk("lit_use3_valid", 128'(qif.o_is_valid), 128'(2'b00));
    cyc(0, 0, 2'b10, 32'h1c000300, 32'h1c000304, 2'd0);
    cyc(0, 0, 2'b00, 32'h0, 32'h0, 2'd2);
    chk("lit_sat_valid", 128'(qif.o_is_valid), 128'(2'b00));

    // Flush at count 5 discards everything including the same-cycle push.
    cyc(0, 0, 2'b11, 32'h1c000400, 32'h1c000404, 2'd0);
    cyc(0, 0, 2'b11, 32'h1c000408, 32'h1c00040c, 2'd0);
    cyc(0, 0, 2'b10, 32'h1c000410, 32'h1c000414, 2'd0);
    cyc(1, 0, 2'b11, 32'h1c000500, 32'h1c000504, 2'd2);
    chk("lit_flush_valid", 128'(qif.o_is_valid), 128'(2'b00));
    chk("lit_flush_ready", 128'(qif.o_ready), 128'(1'b1));
    cyc(0, 0, 2'b11, 32'h1c000600, 32'h1c000604, 2'd0);
    chk("lit_postflush_set1", 128'(qif.o_set1.PC), 128'(32'h1c000600));

    // Asynchronous reset mid-cycle at count 4.
    cyc(0, 0, 2'b11, 32'h1c000700, 32'h1c000704, 2'd0);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("lit_arst_valid", 128'(qif.o_is_valid), 128'(2'b00));
    chk("lit_arst_ready", 128'(qif.o_ready), 128'(1'b1));
    mq.delete();
    @(negedge clk);
    #1;
    rstn = 1'b1;
    cyc(0, 0, 2'b10, 32'h1c000800, 32'h1c000804, 2'd0);
    chk("lit_postrst_set1", 128'(qif.o_set1.PC), 128'(32'h1c000800));
    chk("lit_postrst_valid", 128'(qif.o_is_valid), 128'(2'b10));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the entry count (power of two, >= 4).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port flush  input  1  synchronous discard of all queued entries.
REQ-005 The block SHALL have port stall  input  1  backend stall; when high, no pop occurs.
REQ-006 The block SHALL have port i_set1  input  PC_set  decoded instruction, older of the pushed pair.
REQ-007 The block SHALL have port i_set2  input  PC_set  decoded instruction, younger of the pushed pair.
REQ-008 The block SHALL have port i_valid  input  2  push valids; [1] qualifies i_set1, [0] qualifies i_set2.
REQ-009 The block SHALL have port o_ready  output  1  high when at least two slots are free.
REQ-010 The block SHALL have port o_set1  output  PC_set  oldest queued entry (head).
REQ-011 The block SHALL have port o_set2  output  PC_set  second-oldest entry (head+1, wrapping).
REQ-012 The block SHALL have port o_is_valid  output  2  [1] o_set1 valid, [0] o_set2 valid.
REQ-013 The block SHALL have port i_usingNUM  input  2  entries consumed by issue/dispatch this cycle (0, 1 or 2).

Function
REQ-014 Storage SHALL be a circular buffer of DEPTH PC_set entries with head pointer, tail pointer and occupancy count of clog2(DEPTH)+1 bits.
REQ-015 Pointers SHALL wrap from DEPTH-1 to 0; o_set2 SHALL read index (head+1) mod DEPTH.
REQ-016 o_set1/o_set2 SHALL be combinational reads of storage; o_is_valid[1] = (count >= 1), o_is_valid[0] = (count >= 2).
REQ-017 o_ready SHALL be combinational: count <= DEPTH-2, computed from the current (pre-update) count.
REQ-018 Push SHALL occur only when o_ready is high; with o_ready low the cycle's push is dropped entirely.
REQ-019 Push count: i_valid 2'b11 -> 2 (i_set1 at tail, i_set2 at tail+1); 2'b10 -> 1 (i_set1); 2'b01 -> 1 (i_set2 at tail, compacted); 2'b00 -> 0.
REQ-020 Payload SHALL be stored verbatim, including its o_valid field; o_is_valid is the authoritative valid.
REQ-021 Pop count SHALL be 0 when stall is high, else min(i_usingNUM, count); i_usingNUM = 3 SHALL be treated as 2.
REQ-022 Simultaneous push and pop SHALL both take effect: count_next = count + npush - npop; head += npop; tail += npush.
REQ-023 Order SHALL be strictly FIFO; an entry pushed in cycle N SHALL be visible on o_set* no earlier than cycle N+1.
REQ-024 flush SHALL dominate push and pop: next cycle head = tail = count = 0; same-cycle push discarded; storage contents are not cleared.
REQ-025 Wrap-around: with head = DEPTH-1 and count >= 2, o_set1 SHALL show index DEPTH-1 and o_set2 index 0.

Reset
REQ-026 While rstn is low: head, tail and count SHALL be 0, all storage entries SHALL be cleared to all-zero.
REQ-027 Reset output values: o_ready = 1, o_is_valid = 2'b00, o_set1 = o_set2 = all-zero.
REQ-028 Reset asserted mid-operation SHALL take effect immediately, discarding all entries regardless of stall/flush/push.

Verification (DEPTH = 8)
REQ-029 Reset, push i_valid=11 PCs 0x1c000000/0x1c000004, i_usingNUM=0 -> next cycle o_is_valid=11, o_set1.PC=0x1c000000, o_set2.PC=0x1c000004.
REQ-030 From count 6 push 2 -> count 8, o_ready=0; further push 11 with i_usingNUM=0 dropped, count stays 8; i_usingNUM=2 -> count 6, o_ready=1.
REQ-031 Head at index 7, count 3, push 2 + i_usingNUM=2 same cycle -> count 3, o_set1 = entry formerly at index 1, order preserved across wrap.
REQ-032 stall=1 with i_usingNUM=2 and i_valid=01 (PC 0x1c000100) at count 1 -> count 2, o_set2.PC=0x1c000100, o_set1 unchanged.
REQ-033 flush=1 with i_valid=11 at count 5 -> next cycle count 0, o_is_valid=00, o_ready=1.
REQ-034 rstn pulled low asynchronously at count 4 mid-cycle -> o_is_valid=00 and o_ready=1 before the next clk edge.
